// File: rtl/lsu_axi_master_pkg.sv
// Shared types for the LSU AXI-lite master: FSM states, access sizes, AXI response codes,
// bus widths and the small helpers used by the FSM and the lane aligner.
package lsu_axi_master_pkg;

    localparam int LSU_ADDR_W = 64;
    localparam int LSU_DATA_W = 64;
    localparam int LSU_STRB_W = LSU_DATA_W / 8;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_AW = 3'd3,
        ST_WR_B  = 3'd4,
        ST_RSP   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } size_e;

    // Request fields that the load return path still needs after accept.
    typedef struct packed {
        logic [2:0] off;
        logic [1:0] size;
        logic       uns;
    } req_cap_t;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 8'h01;
            SZ_HALF: return 8'h03;
            SZ_WORD: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_axi_master_if.sv
// Pipeline request/response and single-beat AXI-lite channels of the LSU master port.
interface lsu_axi_master_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0]   ar_addr;
    logic                ar_valid;
    logic                ar_ready;
    logic [ADDR_W-1:0]   aw_addr;
    logic                aw_valid;
    logic                aw_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_valid;
    logic                w_ready;
    logic [1:0]          b_resp;
    logic                b_valid;
    logic                b_ready;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_valid;
    logic                r_ready;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
               ar_ready, aw_ready, w_ready, b_resp, b_valid, r_data, r_resp, r_valid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               ar_addr, ar_valid, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, r_ready
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
               ar_ready, aw_ready, w_ready, b_resp, b_valid, r_data, r_resp, r_valid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               ar_addr, ar_valid, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, r_ready
    );

endinterface

// File: rtl/lsu_axi_master_lane_align.sv
// Byte-lane aligner: store strobe/data placement and load extraction with sign/zero extension.
// Lanes pushed past byte 7 by an unaligned offset are simply dropped.
module lsu_lane_align
    import lsu_axi_master_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic [2:0]          st_off,
    input  logic [1:0]          st_size,
    input  logic [DATA_W-1:0]   st_wdata,
    output logic [DATA_W/8-1:0] st_strb,
    output logic [DATA_W-1:0]   st_data,
    input  logic [2:0]          ld_off,
    input  logic [1:0]          ld_size,
    input  logic                ld_unsigned,
    input  logic [DATA_W-1:0]   ld_raw,
    output logic [DATA_W-1:0]   ld_data
);
    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] sh;

    assign st_strb = STRB_W'(size_mask(st_size) << st_off);
    assign st_data = st_wdata << {st_off, 3'b000};
    assign sh      = ld_raw >> {ld_off, 3'b000};

    always_comb begin
        ld_data = sh;
        case (ld_size)
            SZ_BYTE: ld_data = {{(DATA_W-8){~ld_unsigned & sh[7]}}, sh[7:0]};
            SZ_HALF: ld_data = {{(DATA_W-16){~ld_unsigned & sh[15]}}, sh[15:0]};
            SZ_WORD: ld_data = {{(DATA_W-32){~ld_unsigned & sh[31]}}, sh[31:0]};
            default: ld_data = sh;
        endcase
    end

endmodule

// File: rtl/lsu_axi_master.sv
// LSU AXI-lite master: one blocking load/store at a time, single-beat AR/R or AW/W/B.
// Define LSU_MISALIGN_CHK_EN to fail misaligned requests at accept without any bus traffic.
module lsu_axi_master
    import lsu_axi_master_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
) (
    input logic               clk,
    input logic               rst,
    lsu_axi_master_if.master  bus
);
    localparam int STRB_W = DATA_W / 8;

    state_e              state;
    req_cap_t            cap;
    logic [ADDR_W-1:0]   line_addr;
    logic [STRB_W-1:0]   st_strb;
    logic [DATA_W-1:0]   st_data;
    logic [DATA_W-1:0]   ld_data;
    logic                mis;
    logic                wr_done;

    assign line_addr = {bus.req_addr[ADDR_W-1:3], 3'b000};

`ifdef LSU_MISALIGN_CHK_EN
    assign mis = misaligned(bus.req_addr[2:0], bus.req_size);
`else
    assign mis = 1'b0;
`endif

    // AW and W retire independently; leave once neither is still pending.
    assign wr_done = (!bus.aw_valid || bus.aw_ready) && (!bus.w_valid || bus.w_ready);

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .st_off      (bus.req_addr[2:0]),
        .st_size     (bus.req_size),
        .st_wdata    (bus.req_wdata),
        .st_strb     (st_strb),
        .st_data     (st_data),
        .ld_off      (cap.off),
        .ld_size     (cap.size),
        .ld_unsigned (cap.uns),
        .ld_raw      (bus.r_data),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cap           <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.ar_addr   <= '0;
            bus.ar_valid  <= 1'b0;
            bus.aw_addr   <= '0;
            bus.aw_valid  <= 1'b0;
            bus.w_data    <= '0;
            bus.w_strb    <= '0;
            bus.w_valid   <= 1'b0;
            bus.b_ready   <= 1'b0;
            bus.r_ready   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        cap <= '{off: bus.req_addr[2:0], size: bus.req_size, uns: bus.req_unsigned};
                        if (mis) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                            state         <= ST_RSP;
                        end else if (bus.req_wen) begin
                            bus.aw_addr  <= line_addr;
                            bus.aw_valid <= 1'b1;
                            bus.w_data   <= st_data;
                            bus.w_strb   <= st_strb;
                            bus.w_valid  <= 1'b1;
                            state        <= ST_WR_AW;
                        end else begin
                            bus.ar_addr  <= line_addr;
                            bus.ar_valid <= 1'b1;
                            state        <= ST_RD_A;
                        end
                    end
                end
                ST_RD_A: begin
                    if (bus.ar_ready) begin
                        bus.ar_valid <= 1'b0;
                        bus.r_ready  <= 1'b1;
                        state        <= ST_RD_D;
                    end
                end
                ST_RD_D: begin
                    if (bus.r_valid) begin
                        bus.r_ready   <= 1'b0;
                        bus.rsp_rdata <= ld_data;
                        bus.rsp_err   <= (bus.r_resp != AXI_RESP_OKAY);
                        bus.rsp_valid <= 1'b1;
                        state         <= ST_RSP;
                    end
                end
                ST_WR_AW: begin
                    if (bus.aw_ready) bus.aw_valid <= 1'b0;
                    if (bus.w_ready)  bus.w_valid  <= 1'b0;
                    if (wr_done) begin
                        bus.b_ready <= 1'b1;
                        state       <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (bus.b_valid) begin
                        bus.b_ready   <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= (bus.b_resp != AXI_RESP_OKAY);
                        bus.rsp_valid <= 1'b1;
                        state         <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    bus.req_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- Load/store unit's AXI-lite master port, directly upstream of the LSU memory slave.
- Accepts one load/store request per transaction from the MEM stage over a valid/ready pair.
- Converts each request into a single-beat AXI read (AR/R) or write (AW/W/B), with byte-lane alignment, strobe generation and load sign/zero extension.
- Returns a registered response to the pipeline; blocking, with one outstanding transaction at a time.

Parameters:
- ADDR_W, 64, width of request and AXI addresses
- DATA_W, 64, width of data bus; fixed 8 byte lanes, strobe width DATA_W/8

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req_valid  in  1  MEM-stage request valid
- req_ready  out  1  block can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- req_size  in  2  0=byte 1=half 2=word 3=double
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- rsp_valid  out  1  response valid
- rsp_ready  in  1  pipeline accepts response
- rsp_rdata  out  DATA_W  extended load data; 0 for stores
- rsp_err  out  1  bus error, or misalignment when the optional feature is enabled
- ar_addr  out  ADDR_W, ar_valid  out  1, ar_ready  in  1
- aw_addr  out  ADDR_W, aw_valid  out  1, aw_ready  in  1
- w_data  out  DATA_W, w_strb  out  DATA_W/8, w_valid  out  1, w_ready  in  1
- b_resp  in  2, b_valid  in  1, b_ready  out  1
- r_data  in  DATA_W, r_resp  in  2, r_valid  in  1, r_ready  out  1

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all valid and ready outputs 0 except req_ready=1; all addr/data/strb/rsp outputs 0.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, RSP.
- IDLE, on req_valid & req_ready:
  - Capture request into registers.
  - Go to RD_A if load, WR_AW if store.
  - req_ready=1 only in IDLE.
- Address: ar_addr/aw_addr = {req_addr[ADDR_W-1:3], 3'b0}; off = req_addr[2:0].
- Strobe: base mask 0x01 / 0x03 / 0x0F / 0xFF for size 0..3, shifted left by off, truncated to 8 bits.
- Write data: w_data = req_wdata << (off*8).
- RD_A:
  - ar_valid=1, held with stable ar_addr until ar_ready.
  - On handshake go to RD_D.
- RD_D:
  - r_ready=1.
  - On r_valid: raw = r_data >> (off*8); truncate to size; sign- or zero-extend.
  - Register result into rsp_rdata and rsp_err = (r_resp != 0); go to RSP.
- WR_AW:
  - aw_valid and w_valid asserted together on entry.
  - Each deasserts independently after its own handshake.
  - Once both have completed (same or different cycles), go to WR_B.
- WR_B:
  - b_ready=1.
  - On b_valid: rsp_err = (b_resp != 0), rsp_rdata = 0; go to RSP.
- RSP:
  - rsp_valid=1; rsp_rdata/rsp_err held until rsp_ready, then return to IDLE.
  - No new request is accepted in the same cycle.
- Latency: minimum 3 cycles from request accept to rsp_valid (zero-wait slave, load or store).
- Unaligned accesses that cross the 8-byte boundary: lanes beyond byte 7 are dropped (no split). See Optional Feature.
- Reset mid-transaction: all state abandoned immediately; no response is produced for the aborted request.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Enabled:
  - At accept, a request with (off mod 2^size) != 0 issues no AXI traffic.
  - Goes directly IDLE -> RSP with rsp_err=1, rsp_rdata=0 (latency 1).
- Disabled: no check; behaviour as described above.

Decomposition:
- Shared package/define file:
  - state encodings (3-bit)
  - size encodings
  - AXI resp OKAY=2'b00
  - ADDR/DATA/STRB width macros
- Sub-module lsu_lane_align, purely combinational:
  - store path: strobe generation and data shift
  - load path: shift and extension
  - keeps the FSM file focused on the handshake logic.

Test Plan:
- Load word, addr=0x80000104, unsigned=0, slave r_data=0x80000001_00000000 -> ar_addr=0x80000100, rsp_rdata=0xFFFFFFFF80000001, rsp_err=0.
- Store half, addr=0x80000006, wdata=0xBEEF -> aw_addr=0x80000000, w_strb=0xC0, w_data=0xBEEF000000000000, aw_valid/w_valid high together.
- Write with aw_ready given 2 cycles before w_ready -> aw_valid drops after its handshake, w_valid held, exactly one B accepted, single rsp_valid.
- Slave returns r_resp=2'b10 for a byte load -> rsp_err=1; rsp_rdata held while rsp_ready=0 for 4 cycles.
- rst driven low while in RD_D -> all outputs immediately at reset values; req_ready=1 after release.
- With LSU_MISALIGN_CHK_EN, word load at addr 0x...2 -> ar_valid never asserted, rsp_valid the next cycle with rsp_err=1.
